// File: rtl/ctl_pkg.sv
//==============================================================================
// Module      : ctl_pkg
// Description : Shared opcodes, ALU/branch codes and control bundle type for
//               the RV32I decode stage.
// Revision    : 1.0
//==============================================================================
`default_nettype none

package ctl_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [4:0] ALU_ADD     = 5'h00;
    localparam logic [4:0] ALU_SUB     = 5'h01;
    localparam logic [4:0] ALU_AND     = 5'h02;
    localparam logic [4:0] ALU_OR      = 5'h03;
    localparam logic [4:0] ALU_XOR     = 5'h04;
    localparam logic [4:0] ALU_SLL     = 5'h05;
    localparam logic [4:0] ALU_SRL     = 5'h06;
    localparam logic [4:0] ALU_SRA     = 5'h07;
    localparam logic [4:0] ALU_SLT     = 5'h08;
    localparam logic [4:0] ALU_SLTU    = 5'h09;
    localparam logic [4:0] ALU_PASS_B  = 5'h0A;
    localparam logic [4:0] ALU_M_BASE  = 5'h10;
    localparam logic [4:0] ALU_INVALID = 5'h1F;

    localparam logic [2:0] BJ_NONE = 3'b010;
    localparam logic [2:0] BJ_JUMP = 3'b011;

    localparam logic [1:0] USEL_NONE  = 2'b00;
    localparam logic [1:0] USEL_LUI   = 2'b01;
    localparam logic [1:0] USEL_AUIPC = 2'b10;

    localparam int FMT_R = 0;
    localparam int FMT_I = 1;
    localparam int FMT_S = 2;
    localparam int FMT_B = 3;
    localparam int FMT_U = 4;
    localparam int FMT_J = 5;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [4:0] alu_op;
        logic [2:0] bj_type;
        logic [1:0] u_sel;
        logic [5:0] i_format;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       illegal;
    } ctl_bundle_t;

    // arith only matters for funct3=101 (SRA vs SRL); SUB is handled by the caller
    function automatic logic [4:0] base_alu_op(input logic [2:0] f3, input logic arith);
        logic [4:0] op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = arith ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ctl_decode.sv
//==============================================================================
// Module      : ctl_decode
// Description : Combinational RV32I(+M) instruction decoder producing the
//               control bundle and source-register usage flags.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module ctl_decode
    import ctl_pkg::*;
#(
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [31:0] i_instr,
    output ctl_bundle_t o_ctl,
    output logic        o_rs1_used,
    output logic        o_rs2_used
);

    logic [6:0] w_opcode;
    logic [6:0] w_funct7;
    logic [2:0] w_funct3;
    logic       w_bad;

    assign w_opcode = i_instr[6:0];
    assign w_funct7 = i_instr[31:25];
    assign w_funct3 = i_instr[14:12];

    always_comb begin
        w_bad          = 1'b0;
        o_ctl          = '0;
        o_ctl.rd       = i_instr[11:7];
        o_ctl.rs1      = i_instr[19:15];
        o_ctl.rs2      = i_instr[24:20];
        o_ctl.funct3   = w_funct3;
        o_ctl.bj_type  = BJ_NONE;
        case (w_opcode)
            OPC_OP: begin
                o_ctl.i_format[FMT_R] = 1'b1;
                o_ctl.reg_write       = 1'b1;
                case (w_funct7)
                    7'b0000000: o_ctl.alu_op = base_alu_op(w_funct3, 1'b0);
                    7'b0100000: begin
                        if (w_funct3 == 3'b000)
                            o_ctl.alu_op = ALU_SUB;
                        else if (w_funct3 == 3'b101)
                            o_ctl.alu_op = ALU_SRA;
                        else
                            w_bad = 1'b1;
                    end
                    7'b0000001: begin
                        if (ENABLE_M)
                            o_ctl.alu_op = ALU_M_BASE | {2'b00, w_funct3};
                        else
                            w_bad = 1'b1;
                    end
                    default: w_bad = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                o_ctl.i_format[FMT_I] = 1'b1;
                o_ctl.alu_src         = 1'b1;
                o_ctl.reg_write       = 1'b1;
                o_ctl.alu_op          = base_alu_op(w_funct3, i_instr[30]);
            end
            OPC_LOAD: begin
                o_ctl.i_format[FMT_I] = 1'b1;
                o_ctl.alu_op          = ALU_ADD;
                o_ctl.mem_read        = 1'b1;
                o_ctl.mem_to_reg      = 1'b1;
                o_ctl.alu_src         = 1'b1;
                o_ctl.reg_write       = 1'b1;
            end
            OPC_STORE: begin
                o_ctl.i_format[FMT_S] = 1'b1;
                o_ctl.alu_op          = ALU_ADD;
                o_ctl.mem_write       = 1'b1;
                o_ctl.alu_src         = 1'b1;
            end
            OPC_BRANCH: begin
                o_ctl.i_format[FMT_B] = 1'b1;
                o_ctl.alu_op          = ALU_SUB;
                o_ctl.bj_type         = w_funct3;
                w_bad                 = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
            end
            OPC_LUI: begin
                o_ctl.i_format[FMT_U] = 1'b1;
                o_ctl.alu_op          = ALU_PASS_B;
                o_ctl.u_sel           = USEL_LUI;
                o_ctl.alu_src         = 1'b1;
                o_ctl.reg_write       = 1'b1;
            end
            OPC_AUIPC: begin
                o_ctl.i_format[FMT_U] = 1'b1;
                o_ctl.alu_op          = ALU_ADD;
                o_ctl.u_sel           = USEL_AUIPC;
                o_ctl.alu_src         = 1'b1;
                o_ctl.reg_write       = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                o_ctl.i_format[FMT_J] = (w_opcode == OPC_JAL);
                o_ctl.i_format[FMT_I] = (w_opcode == OPC_JALR);
                o_ctl.alu_op          = ALU_ADD;
                o_ctl.bj_type         = BJ_JUMP;
                o_ctl.alu_src         = 1'b1;
                o_ctl.reg_write       = 1'b1;
            end
            default: w_bad = 1'b1;
        endcase

        // Illegal words still travel down the pipe, stripped of side effects
        if (w_bad) begin
            o_ctl.illegal    = 1'b1;
            o_ctl.alu_op     = ALU_INVALID;
            o_ctl.i_format   = '0;
            o_ctl.bj_type    = BJ_NONE;
            o_ctl.u_sel      = USEL_NONE;
            o_ctl.reg_write  = 1'b0;
            o_ctl.mem_read   = 1'b0;
            o_ctl.mem_to_reg = 1'b0;
            o_ctl.mem_write  = 1'b0;
            o_ctl.alu_src    = 1'b0;
        end
    end

    assign o_rs1_used = o_ctl.i_format[FMT_R] | o_ctl.i_format[FMT_I]
                      | o_ctl.i_format[FMT_S] | o_ctl.i_format[FMT_B];
    assign o_rs2_used = o_ctl.i_format[FMT_R] | o_ctl.i_format[FMT_S]
                      | o_ctl.i_format[FMT_B];

endmodule

`default_nettype wire

// File: rtl/ctl_pipe.sv
//==============================================================================
// Module      : ctl_pipe
// Description : Registered decode stage with valid/ready handshake, load-use
//               bubble insertion, flush and saturating bubble counter.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module ctl_pipe
    import ctl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit ENABLE_M     = 1'b0,
    parameter bit HAZARD_CHECK = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [4:0]       out_alu_op,
    output logic [2:0]       out_bj_type,
    output logic [1:0]       out_u_sel,
    output logic [5:0]       out_i_format,
    output logic             out_mem_read,
    output logic             out_mem_to_reg,
    output logic             out_mem_write,
    output logic             out_alu_src,
    output logic             out_reg_write,
    output logic             out_illegal,
    output logic [CNT_W-1:0] bubble_cnt
);

    ctl_bundle_t      w_dec;
    logic             w_rs1_used;
    logic             w_rs2_used;
    logic             w_hazard;
    logic             w_in_ready;

    ctl_bundle_t      r_ctl;
    logic             r_valid;
    logic [XLEN-1:0]  r_pc;
    logic [CNT_W-1:0] r_cnt;

    ctl_decode #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .i_instr    (in_instr),
        .o_ctl      (w_dec),
        .o_rs1_used (w_rs1_used),
        .o_rs2_used (w_rs2_used)
    );

    // Load in the register whose result the incoming instruction needs
    assign w_hazard = HAZARD_CHECK && r_valid && r_ctl.mem_read && (r_ctl.rd != 5'd0)
                   && in_valid
                   && ((w_rs1_used && (w_dec.rs1 == r_ctl.rd))
                    || (w_rs2_used && (w_dec.rs2 == r_ctl.rd)));

    assign w_in_ready = !flush && !w_hazard && (!r_valid || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid       <= 1'b0;
            r_ctl         <= '0;
            r_ctl.bj_type <= BJ_NONE;
            r_pc          <= '0;
            r_cnt         <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (in_valid && w_in_ready) begin
            r_valid <= 1'b1;
            r_ctl   <= w_dec;
            r_pc    <= in_pc;
        end else if (w_hazard && out_ready) begin
            r_valid <= 1'b0;
            if (!(&r_cnt))
                r_cnt <= r_cnt + 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign in_ready       = w_in_ready;
    assign out_valid      = r_valid;
    assign out_pc         = r_pc;
    assign out_rd         = r_ctl.rd;
    assign out_rs1        = r_ctl.rs1;
    assign out_rs2        = r_ctl.rs2;
    assign out_funct3     = r_ctl.funct3;
    assign out_alu_op     = r_ctl.alu_op;
    assign out_bj_type    = r_ctl.bj_type;
    assign out_u_sel      = r_ctl.u_sel;
    assign out_i_format   = r_ctl.i_format;
    assign out_mem_read   = r_ctl.mem_read;
    assign out_mem_to_reg = r_ctl.mem_to_reg;
    assign out_mem_write  = r_ctl.mem_write;
    assign out_alu_src    = r_ctl.alu_src;
    assign out_reg_write  = r_ctl.reg_write;
    assign out_illegal    = r_ctl.illegal;
    assign bubble_cnt     = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ctl_pipe.sv
//==============================================================================
// Module      : tb_ctl_pipe
// Description : Randomised + directed bench for ctl_pipe, two instances
//               (base ISA / 16-bit counter and M-ext / 2-bit counter).
// Revision    : 1.0
//==============================================================================
`default_nettype none

module tb_ctl_pipe;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] f3;
        logic [4:0] alu;
        logic [2:0] bj;
        logic [1:0] us;
        logic [5:0] fmt;
        logic       mr, m2r, mw, asrc, rw, ill;
        logic       use1, use2;
    } exp_t;

    localparam logic [31:0] I_ADD    = 32'h002081B3;
    localparam logic [31:0] I_LW     = 32'h0000A283;
    localparam logic [31:0] I_ADDDEP = 32'h00228333;
    localparam logic [31:0] I_ADDIND = 32'h00238333;
    localparam logic [31:0] I_MUL    = 32'h022081B3;
    localparam logic [31:0] I_BEQ    = 32'h00208063;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;

    logic        d0_rdy, d0_v, d0_mr, d0_m2r, d0_mw, d0_as, d0_rw, d0_il;
    logic [31:0] d0_pc;
    logic [4:0]  d0_rd, d0_rs1, d0_rs2, d0_alu;
    logic [2:0]  d0_f3, d0_bj;
    logic [1:0]  d0_us;
    logic [5:0]  d0_fmt;
    logic [15:0] d0_cnt;

    logic        d1_rdy, d1_v, d1_mr, d1_m2r, d1_mw, d1_as, d1_rw, d1_il;
    logic [31:0] d1_pc;
    logic [4:0]  d1_rd, d1_rs1, d1_rs2, d1_alu;
    logic [2:0]  d1_f3, d1_bj;
    logic [1:0]  d1_us;
    logic [5:0]  d1_fmt;
    logic [1:0]  d1_cnt;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] pc_ctr = 32'h1000;

    bit          mv   [2];
    exp_t        mb   [2];
    logic [31:0] mpc  [2];
    int          mcnt [2];
    bit          MEN  [2] = '{1'b0, 1'b1};
    int          MMAX [2] = '{65535, 3};

    always #5 clk = ~clk;

    ctl_pipe u_dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d0_rdy),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(d0_v), .out_ready(out_ready),
        .out_pc(d0_pc), .out_rd(d0_rd), .out_rs1(d0_rs1), .out_rs2(d0_rs2),
        .out_funct3(d0_f3), .out_alu_op(d0_alu), .out_bj_type(d0_bj), .out_u_sel(d0_us),
        .out_i_format(d0_fmt), .out_mem_read(d0_mr), .out_mem_to_reg(d0_m2r),
        .out_mem_write(d0_mw), .out_alu_src(d0_as), .out_reg_write(d0_rw),
        .out_illegal(d0_il), .bubble_cnt(d0_cnt)
    );

    ctl_pipe #(.ENABLE_M(1'b1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d1_rdy),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(d1_v), .out_ready(out_ready),
        .out_pc(d1_pc), .out_rd(d1_rd), .out_rs1(d1_rs1), .out_rs2(d1_rs2),
        .out_funct3(d1_f3), .out_alu_op(d1_alu), .out_bj_type(d1_bj), .out_u_sel(d1_us),
        .out_i_format(d1_fmt), .out_mem_read(d1_mr), .out_mem_to_reg(d1_m2r),
        .out_mem_write(d1_mw), .out_alu_src(d1_as), .out_reg_write(d1_rw),
        .out_illegal(d1_il), .bubble_cnt(d1_cnt)
    );

    function automatic logic [4:0] alu_of(input logic [2:0] f3, input logic arith);
        case (f3)
            3'd0:    return 5'h00;
            3'd1:    return 5'h05;
            3'd2:    return 5'h08;
            3'd3:    return 5'h09;
            3'd4:    return 5'h04;
            3'd5:    return arith ? 5'h07 : 5'h06;
            3'd6:    return 5'h03;
            default: return 5'h02;
        endcase
    endfunction

    function automatic exp_t mdec(input logic [31:0] ins, input bit men);
        exp_t e;
        e     = '0;
        e.rd  = ins[11:7];
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.f3  = ins[14:12];
        e.bj  = 3'b010;
        case (ins[6:0])
            7'h33: begin
                e.fmt = 6'b000001; e.rw = 1'b1;
                if (ins[31:25] == 7'h00)                      e.alu = alu_of(e.f3, 1'b0);
                else if (ins[31:25] == 7'h20 && e.f3 == 3'd0) e.alu = 5'h01;
                else if (ins[31:25] == 7'h20 && e.f3 == 3'd5) e.alu = 5'h07;
                else if (ins[31:25] == 7'h01 && men)          e.alu = {2'b10, e.f3};
                else                                          e.ill = 1'b1;
            end
            7'h13: begin e.fmt = 6'b000010; e.asrc = 1'b1; e.rw = 1'b1; e.alu = alu_of(e.f3, ins[30]); end
            7'h03: begin e.fmt = 6'b000010; e.mr = 1'b1; e.m2r = 1'b1; e.asrc = 1'b1; e.rw = 1'b1; end
            7'h23: begin e.fmt = 6'b000100; e.mw = 1'b1; e.asrc = 1'b1; end
            7'h63: begin
                e.fmt = 6'b001000; e.alu = 5'h01; e.bj = e.f3;
                e.ill = (e.f3 == 3'd2) || (e.f3 == 3'd3);
            end
            7'h37: begin e.fmt = 6'b010000; e.alu = 5'h0A; e.us = 2'b01; e.asrc = 1'b1; e.rw = 1'b1; end
            7'h17: begin e.fmt = 6'b010000; e.us = 2'b10; e.asrc = 1'b1; e.rw = 1'b1; end
            7'h6F: begin e.fmt = 6'b100000; e.bj = 3'b011; e.asrc = 1'b1; e.rw = 1'b1; end
            7'h67: begin e.fmt = 6'b000010; e.bj = 3'b011; e.asrc = 1'b1; e.rw = 1'b1; end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) begin
            e.alu = 5'h1F; e.fmt = '0; e.bj = 3'b010; e.us = '0;
            e.rw = 1'b0; e.mr = 1'b0; e.m2r = 1'b0; e.mw = 1'b0; e.asrc = 1'b0;
        end
        e.use1 = |e.fmt[3:0];
        e.use2 = e.fmt[0] | e.fmt[2] | e.fmt[3];
        return e;
    endfunction

    function automatic logic [71:0] pack(input logic [31:0] pc, input exp_t e);
        return {pc, e.rd, e.rs1, e.rs2, e.f3, e.alu, e.bj, e.us, e.fmt,
                e.mr, e.m2r, e.mw, e.asrc, e.rw, e.ill};
    endfunction

    function automatic logic [71:0] obs(input int k);
        if (k == 0)
            return {d0_pc, d0_rd, d0_rs1, d0_rs2, d0_f3, d0_alu, d0_bj, d0_us, d0_fmt,
                    d0_mr, d0_m2r, d0_mw, d0_as, d0_rw, d0_il};
        return {d1_pc, d1_rd, d1_rs1, d1_rs2, d1_f3, d1_alu, d1_bj, d1_us, d1_fmt,
                d1_mr, d1_m2r, d1_mw, d1_as, d1_rw, d1_il};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] gen();
        logic [31:0] w;
        logic [6:0]  op;
        w  = $urandom;
        op = 7'($urandom);
        case ($urandom_range(0, 11))
            0, 1:    op = 7'h33;
            2:       op = 7'h13;
            3, 4:    op = 7'h03;
            5:       op = 7'h23;
            6:       op = 7'h63;
            7:       op = 7'h37;
            8:       op = 7'h17;
            9:       op = 7'h6F;
            10:      op = 7'h67;
            default: ;
        endcase
        w[6:0]   = op;
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        if (op == 7'h33) begin
            case ($urandom_range(0, 3))
                0:       w[31:25] = 7'h00;
                1:       w[31:25] = 7'h20;
                2:       w[31:25] = 7'h01;
                default: ;
            endcase
        end
        return w;
    endfunction

    // One cycle: drive, check against the model, clock, advance the model
    task automatic step(input bit r, input bit f, input bit iv,
                        input logic [31:0] ins, input bit ordy);
        exp_t d [2];
        bit   hz [2];
        bit   rdy [2];
        rst = r; flush = f; in_valid = iv; in_instr = ins; in_pc = pc_ctr; out_ready = ordy;
        pc_ctr = pc_ctr + 32'd4;
        #1;
        for (int k = 0; k < 2; k++) begin
            d[k]   = mdec(ins, MEN[k]);
            hz[k]  = mv[k] && mb[k].mr && (mb[k].rd != 5'd0) && iv
                  && ((d[k].use1 && d[k].rs1 == mb[k].rd) || (d[k].use2 && d[k].rs2 == mb[k].rd));
            rdy[k] = !f && !hz[k] && (!mv[k] || ordy);
            chk($sformatf("in_ready[%0d]", k), 128'(k == 0 ? d0_rdy : d1_rdy), 128'(rdy[k]));
            chk($sformatf("out_valid[%0d]", k), 128'(k == 0 ? d0_v : d1_v), 128'(mv[k]));
            chk($sformatf("bubble_cnt[%0d]", k), (k == 0) ? 128'(d0_cnt) : 128'(d1_cnt), 128'(mcnt[k]));
            if (mv[k])
                chk($sformatf("bundle[%0d]", k), 128'(obs(k)), 128'(pack(mpc[k], mb[k])));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                mv[k] = 1'b0; mcnt[k] = 0;
            end else if (f) begin
                mv[k] = 1'b0;
            end else if (iv && rdy[k]) begin
                mv[k] = 1'b1; mb[k] = d[k]; mpc[k] = in_pc;
            end else if (hz[k] && ordy) begin
                mv[k] = 1'b0;
                if (mcnt[k] < MMAX[k]) mcnt[k]++;
            end else if (ordy) begin
                mv[k] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        exp_t        pin;
        logic [31:0] beq_pc;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin mv[k] = 1'b0; mcnt[k] = 0; mb[k] = '0; mpc[k] = '0; end
        rst = 1'b0;
        #1;
        chk("rst_valid", 128'(d0_v), 128'(0));
        chk("rst_cnt", 128'(d0_cnt), 128'(0));
        chk("rst_bj", 128'(d0_bj), 128'(3'b010));
        chk("rst_alu", 128'(d0_alu), 128'(0));
        chk("rst_ctl", 128'({d0_rw, d0_mr, d0_mw, d0_il, d0_fmt}), 128'(0));
        chk("rst_in_ready", 128'(d1_rdy), 128'(1));

        pin = mdec(I_ADD, 1'b0);
        chk("pin_add", 128'({pin.alu, pin.fmt, pin.rw, pin.rd}), 128'({5'h00, 6'b000001, 1'b1, 5'd3}));
        pin = mdec(I_MUL, 1'b0);
        chk("pin_mul", 128'({pin.alu, pin.ill, pin.rw}), 128'({5'h1F, 1'b1, 1'b0}));
        pin = mdec(I_LW, 1'b0);
        chk("pin_lw", 128'({pin.mr, pin.rd, pin.use1, pin.use2}), 128'({1'b1, 5'd5, 1'b1, 1'b0}));

        step(1, 0, 0, '0, 1);
        step(0, 0, 1, I_ADD, 1);
        chk("add_valid", 128'(d0_v), 128'(1));
        chk("add_fields", 128'({d0_alu, d0_rw, d0_fmt, d0_rd}), 128'({5'h00, 1'b1, 6'b000001, 5'd3}));

        step(1, 0, 0, '0, 1);
        step(0, 0, 1, I_LW, 1);
        step(0, 0, 1, I_ADDDEP, 1);
        chk("bubble_valid", 128'(d0_v), 128'(0));
        chk("bubble_cnt1", 128'(d0_cnt), 128'(1));
        step(0, 0, 1, I_ADDDEP, 1);
        chk("dep_after_bubble", 128'({d0_v, d0_rd, d0_rs1}), 128'({1'b1, 5'd6, 5'd5}));

        step(1, 0, 0, '0, 1);
        step(0, 0, 1, I_LW, 1);
        step(0, 0, 1, I_ADDIND, 1);
        chk("indep_no_bubble", 128'({d0_v, d0_rd, d0_cnt}), 128'({1'b1, 5'd6, 16'd0}));

        step(1, 0, 0, '0, 1);
        step(0, 0, 1, I_MUL, 1);
        chk("mul_noM", 128'({d0_il, d0_alu, d0_rw}), 128'({1'b1, 5'h1F, 1'b0}));
        chk("mul_M", 128'({d1_il, d1_alu, d1_rw}), 128'({1'b0, 5'h10, 1'b1}));

        step(1, 0, 0, '0, 1);
        beq_pc = pc_ctr;
        step(0, 0, 1, I_BEQ, 1);
        repeat (3) step(0, 0, 1, I_ADD, 0);
        chk("beq_held", 128'({d0_v, d0_bj, d0_pc, d0_rdy}), 128'({1'b1, 3'b000, beq_pc, 1'b0}));
        step(0, 1, 1, I_ADD, 1);
        chk("flush_valid", 128'(d0_v), 128'(0));

        step(1, 0, 0, '0, 1);
        step(0, 0, 1, I_LW, 1);
        step(0, 1, 1, I_ADDDEP, 1);
        chk("flush_hazard", 128'({d0_v, d0_cnt}), 128'(0));

        step(1, 0, 0, '0, 1);
        step(0, 0, 1, I_LW, 1);
        repeat (2) step(0, 0, 1, I_ADDDEP, 0);
        chk("stall_hazard", 128'({d0_v, d0_rd, d0_cnt}), 128'({1'b1, 5'd5, 16'd0}));
        step(0, 0, 1, I_ADDDEP, 1);
        chk("stall_release", 128'({d0_v, d0_cnt}), 128'({1'b0, 16'd1}));

        step(1, 0, 0, '0, 1);
        repeat (5) begin
            step(0, 0, 1, I_LW, 1);
            step(0, 0, 1, I_ADDDEP, 1);
            step(0, 0, 1, I_ADDDEP, 1);
        end
        chk("sat_cnt2", 128'(d1_cnt), 128'(3));
        chk("cnt16_five", 128'(d0_cnt), 128'(5));

        repeat (4000)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 4) != 0, gen(), $urandom_range(0, 3) != 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ctl_pipe.md
# ctl_pipe

Registered, parametrised instruction-decode stage between fetch and execute. Decodes one 32-bit RV32I instruction per cycle into a control bundle, with optional M-extension ops. Holds the bundle in a single-entry valid/ready pipeline register. Detects load-use hazards against the held entry, inserts one bubble per hazard, supports flush, and counts inserted bubbles.

## Interface
- `XLEN`, 32: PC width.
- `ENABLE_M`, 0: when 1, decode MUL/DIV ops; when 0, they are illegal.
- `HAZARD_CHECK`, 1: when 0, load-use detection is disabled and no bubbles are inserted.
- `CNT_W`, 16: width of the bubble counter.
- `clk` in 1: clock. Single clock domain. Reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: discard held entry; nothing accepted this cycle.
- `in_valid` in 1, `in_ready` out 1: fetch-side handshake.
- `in_instr` in 32: instruction word.
- `in_pc` in XLEN: instruction PC.
- `out_valid` out 1, `out_ready` in 1: execute-side handshake.
- `out_pc` out XLEN: registered PC.
- `out_rd`, `out_rs1`, `out_rs2` out 5 each: instruction fields.
- `out_funct3` out 3: instruction field.
- `out_alu_op` out 5:
  - 0x00 ADD, 0x01 SUB, 0x02 AND, 0x03 OR, 0x04 XOR, 0x05 SLL, 0x06 SRL, 0x07 SRA, 0x08 SLT, 0x09 SLTU, 0x0A PASS_B.
  - 0x10|funct3 for M ops.
  - 0x1F invalid.
- `out_bj_type` out 3: branch funct3 for branches; 011 for JAL/JALR; 010 none.
- `out_u_sel` out 2: 01 LUI, 10 AUIPC, 00 otherwise.
- `out_i_format` out 6: one-hot [0]R [1]I (incl. load, JALR) [2]S [3]B [4]U [5]J.
- `out_mem_read`, `out_mem_to_reg`, `out_mem_write`, `out_alu_src`, `out_reg_write`, `out_illegal` out 1 each.
- `bubble_cnt` out CNT_W: saturating count of inserted bubbles.

## Operation
- Decode table:
  - R (0110011): alu_src=0, reg_write=1. funct7 = 0000000 selects the base op; 0100000 selects SUB (f3=000) or SRA (f3=101). 0000001 with ENABLE_M=1 selects 0x10|f3. Anything else is illegal.
  - OP-IMM (0010011): alu_src=1, reg_write=1, ALU op by funct3. For f3=101, bit30 selects SRAI.
  - LOAD (0000011): ADD, mem_read=1, mem_to_reg=1, alu_src=1, reg_write=1.
  - STORE (0100011): ADD, mem_write=1, alu_src=1.
  - BRANCH (1100011): SUB, alu_src=0. funct3 ∈ {010, 011} is illegal.
  - LUI (0110111): PASS_B, alu_src=1, reg_write=1.
  - AUIPC (0010111): ADD, alu_src=1, reg_write=1.
  - JAL (1101111) and JALR (1100111): ADD, alu_src=1, reg_write=1.
- Illegal instructions (any other opcode or invalid funct):
  - illegal=1, alu_op=0x1F, i_format=0, bj_type=010.
  - reg_write, mem_read, mem_write all 0.
  - Still delivered with out_valid=1 so execute can trap.
- Source use:
  - rs1 is used by R, I, S, B formats.
  - rs2 is used by R, S, B formats.
  - rs1 is not used by LUI, AUIPC, JAL.
- Hazard condition (HAZARD_CHECK=1): all of the following hold:
  - out_valid && out_mem_read && out_rd != 0, and
  - in_valid, and
  - the incoming instruction uses a source equal to out_rd.
- `in_ready = !flush && !hazard && (!out_valid || out_ready)`.
- Register update, in priority order:
  1. `rst`: out_valid=0, all control outputs 0, bj_type=010, out_alu_op=0, bubble_cnt=0.
  2. `flush`: out_valid=0.
  3. `in_valid && in_ready`: load the decoded bundle, out_valid=1.
  4. `hazard && out_ready`: load bubble (out_valid=0); bubble_cnt += 1, saturating at all-ones.
  5. `out_ready`: out_valid=0.
  6. Otherwise: hold the register.
- Held bundle stays stable while out_valid && !out_ready.

## Timing
- Decode latency is 1 cycle: an instruction accepted at edge N is presented from N+1.
- Throughput is 1 per cycle with no hazard.
- Load followed by a dependent instruction gives exactly one bubble cycle between them.
- Hazard with downstream stalled: hold the load, keep in_ready=0, and count no bubble until the load leaves.
- flush and a hazard together: flush wins; no bubble is counted.
- Reset mid-stream: the held entry is lost; in_ready=1 on the first cycle after reset.
- bubble_cnt saturates and does not wrap.

## Structure
- Package `ctl_pkg` holds:
  - opcode localparams;
  - alu_op codes (ALU_ADD…ALU_PASS_B, ALU_M_BASE, ALU_INVALID);
  - bj_type codes;
  - i_format bit indices;
  - a packed `ctl_bundle_t` struct.
- Sub-module `ctl_decode`: purely combinational, instr → ctl_bundle_t plus rs1_used/rs2_used, parameter ENABLE_M.
- `ctl_pipe` instantiates `ctl_decode` and holds the register, hazard logic and counter.

## Test plan
- Reset, then `add x3,x1,x2` (0x002081B3) with ready held high → next cycle: out_valid=1, alu_op=0x00, reg_write=1, i_format=000001, rd=3.
- `lw x5,0(x1)` then `add x6,x5,x2`, back-to-back with out_ready=1:
  - one cycle with out_valid=0 between them;
  - bubble_cnt=1.
- Same load followed by `add x6,x7,x2` → no bubble; bubble_cnt stays 0.
- `mul x3,x1,x2` (0x022081B3):
  - ENABLE_M=0 → illegal=1, alu_op=0x1F, reg_write=0;
  - ENABLE_M=1 → alu_op=0x10.
- Hold out_ready=0 for 3 cycles with `beq` held → bundle stable, in_ready=0, bj_type=000. Asserting flush → out_valid=0 on the next cycle.
- CNT_W=2 with 5 load-use pairs → bubble_cnt=3, saturated.
